// File: rtl/msg_pkg.sv
// Shared constants and FSM encoding for the message composer slice.
// Contents: buffer depth, the ASCII codes the composer reacts to, and
// the composer state type (EDIT / SEND / RELEASE).
package msg_pkg;

  localparam int unsigned MSG_CHARS = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_MIN   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;

  typedef enum logic [1:0] {
    EDIT    = 2'b00,
    SEND    = 2'b01,
    RELEASE = 2'b10
  } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the keyboard-ready level.
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   key_valid     : scan-code-ready level from the keyboard path
//   key_rise      : high for the cycle in which key_valid first reads 1
// A held key produces a single key_rise.
module key_edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic key_valid,
  output logic key_rise
);

  logic key_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) key_d <= 1'b0;
    else         key_d <= key_valid;
  end

  assign key_rise = key_valid & ~key_d;

endmodule

// File: rtl/message_composer.sv
// Line editor between the PS/2 ASCII converter and the GPIO link
// transmitter. Keystrokes are collected into a MSG_CHARS-character buffer
// (backspace supported); Enter freezes the buffer and raises data_ready
// until the link reports send_done, after which the buffer is cleared.
// Ports:
//   clock, resetn  : system clock, asynchronous active-low reset
//   key_valid      : key-ready level, one keystroke per rising edge
//   key_ascii      : ASCII code sampled with the key_valid edge
//   enable         : composing allowed
//   clear          : synchronous discard of buffer and any send
//   send_done      : link write-complete level
//   message_out    : buffer, char i at bits [8i+7:8i], unused = 8'h20
//   cursor         : characters held, 0..MSG_CHARS
//   data_ready     : send request (SEND state)
//   busy           : high in SEND and RELEASE
//   overflow       : sticky, a printable key was dropped on a full buffer
//   sent_pulse     : one-cycle pulse on send completion
//   send_timeout   : one-cycle pulse when a send is abandoned
// Build option: MESSAGE_COMPOSER_SEND_TIMEOUT_EN enables the send
// timeout (TIMEOUT_CYCLES); otherwise send_timeout is constant 0.
module message_composer #(
  parameter int unsigned MSG_CHARS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                key_valid,
  input  logic [7:0]                          key_ascii,
  input  logic                                enable,
  input  logic                                clear,
  input  logic                                send_done,
  output logic [8*MSG_CHARS-1:0]              message_out,
  output logic [$clog2(MSG_CHARS+1)-1:0]      cursor,
  output logic                                data_ready,
  output logic                                busy,
  output logic                                overflow,
  output logic                                sent_pulse,
  output logic                                send_timeout
);
  import msg_pkg::*;

  localparam int unsigned CW = $clog2(MSG_CHARS + 1);

  typedef logic [MSG_CHARS-1:0][7:0] buf_t;

  state_t          state_q, state_d;
  buf_t            buf_q, buf_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic            ovf_q, ovf_d;
  logic            sent_q, sent_d;
  logic            to_q, to_d;
  logic            key_rise;
  logic            timed_out;
  logic            printable;

  key_edge_detect u_key_edge (
    .clock     (clock),
    .resetn    (resetn),
    .key_valid (key_valid),
    .key_rise  (key_rise)
  );

`ifdef MESSAGE_COMPOSER_SEND_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Held at zero while editing, so it always starts from zero on entry to SEND.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == EDIT) cnt_d = '0;
    else                 cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timed_out = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
`endif

  assign printable = (key_ascii >= ASCII_MIN) && (key_ascii <= ASCII_MAX);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cur_d   = cur_q;
    ovf_d   = ovf_q;
    sent_d  = 1'b0;
    to_d    = 1'b0;
    if (clear) begin
      state_d = EDIT;
      buf_d   = {MSG_CHARS{ASCII_SPACE}};
      cur_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        EDIT: begin
          if (key_rise && enable) begin
            if (printable) begin
              if (cur_q < CW'(MSG_CHARS)) begin
                for (int unsigned i = 0; i < MSG_CHARS; i++)
                  if (CW'(i) == cur_q) buf_d[i] = key_ascii;
                cur_d = cur_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end else if (key_ascii == ASCII_BS && cur_q != '0) begin
              for (int unsigned i = 0; i < MSG_CHARS; i++)
                if (CW'(i + 1) == cur_q) buf_d[i] = ASCII_SPACE;
              cur_d = cur_q - 1'b1;
              ovf_d = 1'b0;
            end else if (key_ascii == ASCII_CR && cur_q != '0) begin
              state_d = SEND;
            end
          end
        end
        SEND: begin
          if (timed_out) begin
            state_d = EDIT;
            to_d    = 1'b1;
          end else if (send_done) begin
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          // A completed release wins over a timeout landing on the same cycle.
          if (!send_done) begin
            state_d = EDIT;
            buf_d   = {MSG_CHARS{ASCII_SPACE}};
            cur_d   = '0;
            ovf_d   = 1'b0;
            sent_d  = 1'b1;
          end else if (timed_out) begin
            state_d = EDIT;
            to_d    = 1'b1;
          end
        end
        default: state_d = EDIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= EDIT;
      buf_q   <= {MSG_CHARS{ASCII_SPACE}};
      cur_q   <= '0;
      ovf_q   <= 1'b0;
      sent_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cur_q   <= cur_d;
      ovf_q   <= ovf_d;
      sent_q  <= sent_d;
      to_q    <= to_d;
    end
  end

  assign message_out  = buf_q;
  assign cursor       = cur_q;
  assign data_ready   = (state_q == SEND);
  assign busy         = (state_q == SEND) || (state_q == RELEASE);
  assign overflow     = ovf_q;
  assign sent_pulse   = sent_q;
  assign send_timeout = to_q;

endmodule

// File: tb/tb_message_composer.sv
module tb_message_composer;

  localparam logic [127:0] SPACES = {16{8'h20}};

  logic         clock = 1'b0;
  logic         resetn, key_valid, enable, clear, send_done;
  logic [7:0]   key_ascii;
  logic [127:0] message_out;
  logic [4:0]   cursor;
  logic         data_ready, busy, overflow, sent_pulse, send_timeout;

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  int to_cnt = 0;

  message_composer #(.MSG_CHARS(16), .TIMEOUT_CYCLES(20)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .key_valid    (key_valid),
    .key_ascii    (key_ascii),
    .enable       (enable),
    .clear        (clear),
    .send_done    (send_done),
    .message_out  (message_out),
    .cursor       (cursor),
    .data_ready   (data_ready),
    .busy         (busy),
    .overflow     (overflow),
    .sent_pulse   (sent_pulse),
    .send_timeout (send_timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn === 1'b1 && sent_pulse === 1'b1) sent_cnt++;
    if (resetn === 1'b1 && send_timeout === 1'b1) to_cnt++;
  end

  // Reference model: plain byte array plus a "sending" flag.
  logic [7:0] m_buf [16];
  int         m_cur;
  bit         m_ovf;
  bit         m_send;

  typedef struct packed {
    logic [127:0] msg;
    logic [4:0]   cur;
    logic         ovf;
    logic         dr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         en;
    logic [7:0] k;
    int         cur;
    bit         ovf;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_msg();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_buf[i];
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h20;
    m_cur = 0;
    m_ovf = 1'b0;
    m_send = 1'b0;
  endfunction

  function automatic void m_key(input bit en, input logic [7:0] k);
    if (m_send || !en) return;
    if (k >= 8'h20 && k <= 8'h7E) begin
      if (m_cur < 16) begin
        m_buf[m_cur] = k;
        m_cur++;
      end else m_ovf = 1'b1;
    end else if (k == 8'h08 && m_cur > 0) begin
      m_cur--;
      m_buf[m_cur] = 8'h20;
      m_ovf = 1'b0;
    end else if (k == 8'h0D && m_cur > 0) begin
      m_send = 1'b1;
    end
  endfunction

  task automatic push_exp();
    exp_t e;
    e.msg = m_msg();
    e.cur = 5'(m_cur);
    e.ovf = m_ovf;
    e.dr  = m_send;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_msg"}, message_out, e.msg);
    chk({tag, "_cursor"}, cursor, e.cur);
    chk({tag, "_overflow"}, overflow, e.ovf);
    chk({tag, "_data_ready"}, data_ready, e.dr);
  endtask

  task automatic press(input bit en, input logic [7:0] k);
    @(negedge clock);
    enable = en;
    key_ascii = k;
    key_valid = 1'b1;
    m_key(en, k);
    push_exp();
    @(negedge clock);
    key_valid = 1'b0;
    check_sb("key");
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    m_clear();
    push_exp();
    @(negedge clock);
    clear = 1'b0;
    check_sb("clear");
  endtask

  initial begin
    int n;
    resetn = 1'b0; key_valid = 1'b0; key_ascii = 8'h00;
    enable = 1'b1; clear = 1'b0; send_done = 1'b0;
    m_clear();
    repeat (2) @(negedge clock);
    chk("rst_msg", message_out, SPACES);
    chk("rst_cursor", cursor, 0);
    chk("rst_flags", {data_ready, busy, overflow, sent_pulse, send_timeout}, 0);
    resetn = 1'b1;

    // Basic editing, ignored codes, empty Enter/backspace, enable low.
    tv[0]  = '{1'b1, 8'h48, 1, 1'b0};
    tv[1]  = '{1'b1, 8'h69, 2, 1'b0};
    tv[2]  = '{1'b1, 8'h08, 1, 1'b0};
    tv[3]  = '{1'b1, 8'h08, 0, 1'b0};
    tv[4]  = '{1'b1, 8'h08, 0, 1'b0};
    tv[5]  = '{1'b1, 8'h0D, 0, 1'b0};
    tv[6]  = '{1'b0, 8'h5A, 0, 1'b0};
    tv[7]  = '{1'b1, 8'h07, 0, 1'b0};
    tv[8]  = '{1'b1, 8'h7F, 0, 1'b0};
    tv[9]  = '{1'b1, 8'h7E, 1, 1'b0};
    tv[10] = '{1'b1, 8'h20, 2, 1'b0};
    tv[11] = '{1'b1, 8'h1F, 2, 1'b0};
    for (int i = 0; i < 12; i++) begin
      press(tv[i].en, tv[i].k);
      chk($sformatf("tv%0d_cursor", i), cursor, tv[i].cur);
      chk($sformatf("tv%0d_overflow", i), overflow, tv[i].ovf);
      if (i == 1) begin
        chk("hi_low", message_out[15:0], 16'h6948);
        chk("hi_high", message_out[127:16], SPACES[127:16]);
      end
    end

    // Fill, overflow, backspace clears overflow.
    do_clear();
    for (int i = 0; i < 17; i++) press(1'b1, 8'h41);
    chk("full_msg", message_out, {16{8'h41}});
    chk("full_cursor", cursor, 16);
    chk("full_overflow", overflow, 1'b1);
    press(1'b1, 8'h08);
    chk("bs_slot15", message_out[127:120], 8'h20);
    chk("bs_cursor", cursor, 15);
    chk("bs_overflow", overflow, 1'b0);

    // A held key counts once.
    do_clear();
    @(negedge clock);
    enable = 1'b1; key_ascii = 8'h6B; key_valid = 1'b1;
    m_key(1'b1, 8'h6B);
    repeat (3) @(negedge clock);
    key_valid = 1'b0;
    @(negedge clock);
    chk("held_cursor", cursor, 1);
    chk("held_msg", message_out, m_msg());

    // Clear beats a simultaneous keystroke.
    @(negedge clock);
    clear = 1'b1; key_ascii = 8'h5A; key_valid = 1'b1;
    @(negedge clock);
    clear = 1'b0; key_valid = 1'b0;
    m_clear();
    chk("clr_key_cursor", cursor, 0);
    chk("clr_key_msg", message_out, SPACES);

    // Full send handshake with keys dropped while frozen.
    press(1'b1, 8'h58);
    press(1'b1, 8'h0D);
    chk("send_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) press(1'b1, (i % 2 == 0) ? 8'h51 : 8'h08);
    @(negedge clock);
    send_done = 1'b1;
    @(negedge clock);
    chk("rel_dr", data_ready, 1'b0);
    chk("rel_busy", busy, 1'b1);
    @(negedge clock);
    chk("rel_hold_pulse", sent_pulse, 1'b0);
    @(negedge clock);
    send_done = 1'b0;
    @(negedge clock);
    m_clear();
    chk("done_pulse", sent_pulse, 1'b1);
    chk("done_cursor", cursor, 0);
    chk("done_msg", message_out, SPACES);
    chk("done_busy", busy, 1'b0);
    @(negedge clock);
    chk("done_pulse_end", sent_pulse, 1'b0);
    chk("done_pulse_count", sent_cnt, 1);

    // Clear during SEND beats a simultaneous send_done.
    press(1'b1, 8'h59);
    press(1'b1, 8'h0D);
    @(negedge clock);
    clear = 1'b1; send_done = 1'b1;
    m_clear();
    push_exp();
    @(negedge clock);
    clear = 1'b0; send_done = 1'b0;
    check_sb("clr_send");
    chk("clr_send_busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    chk("clr_send_nopulse", sent_cnt, 1);

    // Asynchronous reset mid-edit and mid-send.
    press(1'b1, 8'h61);
    press(1'b1, 8'h62);
    #1 resetn = 1'b0;
    #1;
    chk("arst_edit_msg", message_out, SPACES);
    chk("arst_edit_cursor", cursor, 0);
    @(negedge clock) resetn = 1'b1;
    m_clear();
    press(1'b1, 8'h63);
    press(1'b1, 8'h0D);
    #1 resetn = 1'b0;
    #1;
    chk("arst_send_flags", {data_ready, busy, overflow, sent_pulse, send_timeout}, 0);
    chk("arst_send_cursor", cursor, 0);
    @(negedge clock) resetn = 1'b1;
    m_clear();

`ifdef MESSAGE_COMPOSER_SEND_TIMEOUT_EN
    press(1'b1, 8'h54);
    press(1'b1, 8'h0D);
    n = 0;
    while (send_timeout !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("to_latency", n, 20);
    chk("to_dr", data_ready, 1'b0);
    chk("to_cursor", cursor, 1);
    chk("to_msg", message_out, m_msg());
    m_send = 1'b0;
    press(1'b1, 8'h0D);
    @(negedge clock) send_done = 1'b1;
    @(negedge clock) send_done = 1'b0;
    @(negedge clock);
    chk("retry_pulse", sent_pulse, 1'b1);
    chk("retry_cursor", cursor, 0);
`else
    n = 0;
    chk("no_timeout", to_cnt + n, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
